// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive path.
//   parity_t   : parity configuration of the receiver
//   rx_state_t : receiver FSM states
//   rx_entry_t : one receive-FIFO word (error tags + data, data LSB-aligned)
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH,
    WAIT_HIGH
  } rx_state_t;

  // Data is LSB-aligned; bits above DATA_BITS are always written as 0.
  typedef struct packed {
    logic       parity_err;
    logic       framing_err;
    logic [8:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Generic synchronous FIFO with first-word fall-through head output.
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : write push_data_i (accepted if not full, or full with pop)
//   push_data_i   : word to write
//   pop_i         : drop the head word (ignored when empty)
//   head_o        : head word, 0 when empty
//   full_o/empty_o: occupancy flags
//   count_o       : number of occupied entries
module rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // A pop frees the slot first, so a push into a full FIFO is accepted
  // when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage carries no reset (plain RAM); the head is gated by empty_o
  // instead so stale contents never reach the outputs after a reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with a tagged receive FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   serial_in     : asynchronous serial line, idles high
//   data_read     : one-cycle pop strobe for the FIFO head
//   rx_data       : head data (first-word fall-through)
//   data_ready    : FIFO not empty
//   framing_error : framing tag of the head entry
//   parity_error  : parity tag of the head entry
//   overrun_error : sticky, a frame was dropped on a full FIFO
//   fifo_count    : occupied FIFO entries
module uart_rx_fifo import uart_rx_pkg::*; #(
  parameter int      DATA_BITS    = 8,
  parameter int      CLKS_PER_BIT = 10,
  parameter parity_t PARITY_MODE  = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            serial_in,
  input  logic                            data_read,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            data_ready,
  output logic                            framing_error,
  output logic                            parity_error,
  output logic                            overrun_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;

  logic                 sync1_q, sync2_q, s_prev_q, s;
  rx_state_t            state_q;
  logic [TW-1:0]        timer_q;
  logic                 tick;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_err_q, framing_err_q;
  logic                 overrun_q;
  rx_entry_t            push_entry, head;
  logic                 push, fifo_full, fifo_empty;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      sync1_q  <= serial_in;
      sync2_q  <= sync1_q;
      s_prev_q <= sync2_q;
    end
  end

  assign s    = sync2_q;
  assign tick = (timer_q == TW'(CLKS_PER_BIT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      timer_q <= tick ? '0 : timer_q + TW'(1);
      case (state_q)
        IDLE: begin
          if (s_prev_q && !s) begin
            state_q       <= START;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
          end
        end
        START: begin
          // Half a bit after the edge: confirm the start bit and restart the
          // timer so every later tick lands in the middle of a bit.
          if (timer_q == TW'(CLKS_PER_BIT/2 - 1)) begin
            timer_q <= '0;
            state_q <= s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q   <= {s, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(DATA_BITS-1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            parity_err_q <= (^shift_q) ^ s ^ (PARITY_MODE == PAR_ODD);
            state_q      <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (!s) framing_err_q <= 1'b1;
            if (bit_cnt_q == BW'(STOP_BITS-1)) begin
              bit_cnt_q <= '0;
              state_q   <= PUSH;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        PUSH: state_q <= framing_err_q ? WAIT_HIGH : IDLE;
        // A held-low line (break) must not look like a new start bit.
        WAIT_HIGH: if (s) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    push_entry                        = '0;
    push_entry.data[DATA_BITS-1:0]    = shift_q;
    push_entry.parity_err             = parity_err_q;
    push_entry.framing_err            = framing_err_q;
  end

  assign push = (state_q == PUSH);

  rx_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (data_read),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // When full the FIFO is non-empty, so a data_read always frees a slot.
  always_ff @(posedge clk) begin
    if (rst)                                 overrun_q <= 1'b0;
    else if (push && fifo_full && !data_read) overrun_q <= 1'b1;
    else if (data_read)                       overrun_q <= 1'b0;
  end

  if (DATA_BITS < 9) begin : g_narrow
    logic unused_data_msbs;
    assign unused_data_msbs = ^head.data[8:DATA_BITS];
  end

  assign rx_data       = head.data[DATA_BITS-1:0];
  assign framing_error = head.framing_err;
  assign parity_error  = head.parity_err;
  assign data_ready    = !fifo_empty;
  assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int C = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ser, rd;
  logic [7:0] rxd [3];
  logic       rdy [3];
  logic       fe  [3];
  logic       pe  [3];
  logic       ovr [3];
  logic [2:0] cnt [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_NONE),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .serial_in(ser[0]), .data_read(rd[0]),
    .rx_data(rxd[0]), .data_ready(rdy[0]), .framing_error(fe[0]),
    .parity_error(pe[0]), .overrun_error(ovr[0]), .fifo_count(cnt[0]));

  uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_EVEN),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .serial_in(ser[1]), .data_read(rd[1]),
    .rx_data(rxd[1]), .data_ready(rdy[1]), .framing_error(fe[1]),
    .parity_error(pe[1]), .overrun_error(ovr[1]), .fifo_count(cnt[1]));

  uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_NONE),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .serial_in(ser[2]), .data_read(rd[2]),
    .rx_data(rxd[2]), .data_ready(rdy[2]), .framing_error(fe[2]),
    .parity_error(pe[2]), .overrun_error(ovr[2]), .fifo_count(cnt[2]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       use_par;
    logic       par_bit;
    int         n_stop;
    logic       last_stop;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(input int inst);
    rd[inst] = 1'b1;
    @(negedge clk);
    rd[inst] = 1'b0;
  endtask

  // Drives one frame starting at a negedge, C cycles per bit. With pop_at_push
  // the data_read pulse is placed on the cycle the receiver pushes the frame:
  // start detect 2 cycles after the line edge, last stop sample C/2+(n-1)*C
  // later, PUSH state, then the FIFO edge.
  task automatic send_frame(input int inst, input logic [7:0] data, input logic use_par,
                            input logic par_bit, input int n_stop, input logic last_stop,
                            input logic hold_low, input logic pop_at_push);
    logic [15:0] fr;
    int          n;
    int          push_cyc;
    fr = '0;
    n  = 1;
    for (int i = 0; i < 8; i++) begin
      fr[n] = data[i];
      n++;
    end
    if (use_par) begin
      fr[n] = par_bit;
      n++;
    end
    for (int i = 0; i < n_stop; i++) begin
      fr[n] = (i == n_stop - 1) ? last_stop : 1'b1;
      n++;
    end
    push_cyc = 3 + C/2 + (n - 1) * C;
    for (int b = 0; b < n; b++) begin
      ser[inst] = fr[b];
      for (int c = 0; c < C; c++) begin
        rd[inst] = pop_at_push && ((b * C + c) == push_cyc);
        @(negedge clk);
      end
    end
    rd[inst]  = 1'b0;
    ser[inst] = hold_low ? 1'b0 : 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h03, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1, 8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{2, 8'h5A, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{2, 8'h11, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    ser = '1;
    rd  = '0;
    wait_n(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_ready", i), rdy[i], 0);
      check($sformatf("rst%0d_count", i), cnt[i], 0);
      check($sformatf("rst%0d_data",  i), rxd[i], 0);
      check($sformatf("rst%0d_ovr",   i), ovr[i], 0);
    end
    rst = 1'b0;
    wait_n(3);

    // Table-driven single frames: receive, inspect head, pop.
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].use_par, vecs[i].par_bit,
                 vecs[i].n_stop, vecs[i].last_stop, 1'b0, 1'b0);
      wait_n(3);
      check($sformatf("v%0d_ready", i), rdy[vecs[i].inst], 1);
      check($sformatf("v%0d_data",  i), rxd[vecs[i].inst], vecs[i].data);
      check($sformatf("v%0d_fe",    i), fe[vecs[i].inst],  vecs[i].exp_fe);
      check($sformatf("v%0d_pe",    i), pe[vecs[i].inst],  vecs[i].exp_pe);
      check($sformatf("v%0d_count", i), cnt[vecs[i].inst], 1);
      pop(vecs[i].inst);
      check($sformatf("v%0d_popped", i), rdy[vecs[i].inst], 0);
      wait_n(3);
    end

    // Even parity: two entries keep their own tags.
    send_frame(1, 8'h03, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    wait_n(2);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_n(3);
    check("par_count", cnt[1], 2);
    check("par_head_pe", pe[1], 1);
    pop(1);
    check("par_second_pe", pe[1], 0);
    check("par_second_data", rxd[1], 8'h03);
    pop(1);

    // Two stop bits, second low, then a held-low break.
    send_frame(2, 8'h5A, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    wait_n(30);
    check("brk_count", cnt[2], 1);
    check("brk_fe", fe[2], 1);
    check("brk_data", rxd[2], 8'h5A);
    check("brk_state", 32'(u_dut2.state_q), 32'(WAIT_HIGH));
    ser[2] = 1'b1;
    wait_n(5);
    pop(2);
    send_frame(2, 8'h11, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    wait_n(3);
    check("brk_next_count", cnt[2], 1);
    check("brk_next_data", rxd[2], 8'h11);
    check("brk_next_fe", fe[2], 0);
    pop(2);

    // Three-cycle glitch is rejected by the mid-start-bit check.
    ser[0] = 1'b0;
    wait_n(3);
    ser[0] = 1'b1;
    wait_n(20);
    check("glitch_count", cnt[0], 0);
    check("glitch_state", 32'(u_dut0.state_q), 32'(IDLE));

    // Overrun: five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      wait_n(2);
    end
    check("ovr_count", cnt[0], 4);
    check("ovr_flag", ovr[0], 1);
    check("ovr_head", rxd[0], 8'h01);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), rxd[0], 8'(i));
      pop(0);
      if (i == 1) check("ovr_clear", ovr[0], 0);
    end
    check("ovr_empty", cnt[0], 0);

    // Full FIFO with a pop on the push cycle: no overrun, count holds.
    for (int i = 0; i < 4; i++) begin
      send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      wait_n(2);
    end
    check("coin_pre_count", cnt[0], 4);
    send_frame(0, 8'h14, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    wait_n(3);
    check("coin_count", cnt[0], 4);
    check("coin_ovr", ovr[0], 0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("coin_pop%0d", i), rxd[0], 8'h10 + 8'(i));
      pop(0);
    end
    check("coin_empty", rdy[0], 0);

    // Reset mid-frame with a full, overrun FIFO.
    for (int i = 0; i < 5; i++) begin
      send_frame(0, 8'h20 + 8'(i), 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      wait_n(2);
    end
    check("mid_pre_ovr", ovr[0], 1);
    ser[0] = 1'b0;
    wait_n(45);
    rst    = 1'b1;
    ser[0] = 1'b1;
    wait_n(1);
    check("mid_rst_ready", rdy[0], 0);
    check("mid_rst_data",  rxd[0], 0);
    check("mid_rst_fe",    fe[0],  0);
    check("mid_rst_pe",    pe[0],  0);
    check("mid_rst_ovr",   ovr[0], 0);
    check("mid_rst_count", cnt[0], 0);
    rst = 1'b0;
    wait_n(20);
    check("mid_discard", cnt[0], 0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_n(3);
    check("mid_after_count", cnt[0], 1);
    check("mid_after_data", rxd[0], 8'hC3);
    check("mid_after_fe", fe[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
